// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction decode plus the ID/EX pipeline register feeding the ALU.
//   Register-file read addresses come straight from the IF/ID instruction so
//   the file can answer in the same cycle; the returned operands and the
//   decoded fields are registered here with one cycle of latency.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   instr_valid_i/instr_i/pc_i IF/ID slot: valid flag, instruction, its PC
//   rs1_addr_o/rs2_addr_o      regfile read addresses (combinational)
//   rs1_data_i/rs2_data_i      regfile read data (same cycle)
//   ex_stall_i                 EX cannot accept: hold the ID/EX register
//   flush_i                    taken branch: kill the decoded slot
//   stall_o                    hold fetch and IF/ID (load-use or EX stall)
//   valid_o .. mem_write_o     registered ID/EX fields to the ALU/EX stage
//   illegal_o                  one-cycle pulse for an undecodable instruction
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_i,
    input  logic [31:0]           instr_i,
    input  logic [WORD_SIZE-1:0]  pc_i,
    output logic [REG_ADDR_W-1:0] rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rs2_addr_o,
    input  logic [WORD_SIZE-1:0]  rs1_data_i,
    input  logic [WORD_SIZE-1:0]  rs2_data_i,
    input  logic                  ex_stall_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [WORD_SIZE-1:0]  pc_o,
    output logic [6:0]            opcode_o,
    output logic [2:0]            funct3_o,
    output logic [6:0]            funct7_o,
    output logic [WORD_SIZE-1:0]  alu_in1_o,
    output logic [WORD_SIZE-1:0]  alu_in2_o,
    output logic [WORD_SIZE-1:0]  immediate_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  reg_write_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;

    // ------------------------------------------------------------------
    // Combinational decode of the IF/ID instruction
    // ------------------------------------------------------------------
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd_field;
    logic [31:0]           imm_raw;
    logic                  legal;
    logic                  writes_rd;
    logic                  is_load;
    logic                  is_store;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  hazard;

    assign opcode     = instr_i[6:0];
    assign rd_field   = instr_i[11:7];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        imm_raw   = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        case (opcode)
            OPCODE_ALU: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                rs2_used  = 1'b1;
            end
            OPCODE_ALU_IMM: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                imm_raw   = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPCODE_LOAD: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm_raw   = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPCODE_STORE: begin
                legal    = 1'b1;
                is_store = 1'b1;
                rs2_used = 1'b1;
                imm_raw  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPCODE_BRANCH: begin
                legal    = 1'b1;
                rs2_used = 1'b1;
                imm_raw  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPCODE_JUMP: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                rs1_used  = 1'b0;
                imm_raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            end
            OPCODE_AUIPC, OPCODE_LUI: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
                rs1_used  = 1'b0;
                imm_raw   = {instr_i[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic                  valid_q,     valid_d;
    logic [WORD_SIZE-1:0]  pc_q,        pc_d;
    logic [6:0]            opcode_q,    opcode_d;
    logic [2:0]            funct3_q,    funct3_d;
    logic [6:0]            funct7_q,    funct7_d;
    logic [WORD_SIZE-1:0]  alu_in1_q,   alu_in1_d;
    logic [WORD_SIZE-1:0]  alu_in2_q,   alu_in2_d;
    logic [WORD_SIZE-1:0]  immediate_q, immediate_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  illegal_q,   illegal_d;

    // A load in EX has no data until MEM, so a consumer in ID must wait a
    // cycle. A load to x0 never produces a value anyone can depend on.
    assign hazard = valid_q & mem_read_q & (rd_q != '0) & instr_valid_i &
                    ((rs1_used & (rs1_addr_o == rd_q)) |
                     (rs2_used & (rs2_addr_o == rd_q)));

    assign stall_o = hazard | ex_stall_i;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7_d    = funct7_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        immediate_d = immediate_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        illegal_d   = illegal_q;

        if (flush_i) begin
            // Killing the slot wins over any hold request.
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (ex_stall_i) begin
            // Hold everything.
        end else if (hazard) begin
            // Insert a bubble; IF/ID holds and re-presents the consumer.
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else begin
            valid_d     = instr_valid_i & legal;
            illegal_d   = instr_valid_i & ~legal;
            pc_d        = pc_i;
            opcode_d    = opcode;
            funct3_d    = instr_i[14:12];
            funct7_d    = instr_i[31:25];
            alu_in1_d   = rs1_data_i;
            alu_in2_d   = rs2_data_i;
            immediate_d = WORD_SIZE'($signed(imm_raw));
            rd_d        = rd_field;
            reg_write_d = writes_rd & (rd_field != '0);
            mem_read_d  = is_load;
            mem_write_d = is_store;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            immediate_q <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            immediate_q <= immediate_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign opcode_o    = opcode_q;
    assign funct3_o    = funct3_q;
    assign funct7_o    = funct7_q;
    assign alu_in1_o   = alu_in1_q;
    assign alu_in2_o   = alu_in2_q;
    assign immediate_o = immediate_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign illegal_o   = illegal_q;

endmodule
